board_event_detector: RTL and testbench
=======================================

Name: board_event_detector

Overview:
- Downstream of the sensor shift-register reader.
- Consumes completed 32-bit board-sensor frames and debounces each square over consecutive frames.
- Converts stable occupancy changes into single-square lift/place events.
- Events go to the CPU/game logic over a valid/ready handshake, lowest square index first.

Parameters:
- STABLE_FRAMES, 3: consecutive identical frames needed before a square's stable state updates. Legal range 1..15.
- CNT_W, 4: width of each per-square agreement counter. Must satisfy 2^CNT_W > STABLE_FRAMES.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset_n  input  1  reset, synchronous, active-low.
- frame_data  input  32  raw occupancy of a completed frame; bit i = square i, 1 = piece present.
- frame_valid  input  1  one-cycle pulse; frame_data is valid in that cycle.
- stable_board  output  32  debounced occupancy, registered.
- event_valid  output  1  event register holds an unconsumed event.
- event_ready  input  1  consumer accepts the event this cycle.
- event_square  output  5  square index of the event.
- event_placed  output  1  1 = piece now present, 0 = piece lifted.
- baseline_done  output  1  set once every square has reached STABLE_FRAMES agreement; sticky until reset.

Behaviour:
- Reset (reset_n=0 at a posedge): all of the following clear to 0 — candidate[31:0], count[i], stable_board, reported[31:0], event_valid, event_square, event_placed, baseline_done. Reset mid-handshake drops the held event.
- Per-square debounce, evaluated only in cycles with frame_valid=1:
  - If frame_data[i] != candidate[i]: candidate[i] <= frame_data[i], count[i] <= 1.
  - Else: count[i] <= min(count[i]+1, STABLE_FRAMES).
  - When the next count equals STABLE_FRAMES, stable_board[i] <= candidate value on the same edge.
  - With STABLE_FRAMES=1, stable_board follows frame_data on every valid frame.
  - Frames with frame_valid=0 are ignored; there is no timeout.
- Pending set: pending = stable_board ^ reported (combinational).
  - A square that changes and then reverts before it is loaded cancels itself and emits no event.
- Event register: loads when event_valid=0, or when event_valid=1 and event_ready=1 (same-cycle refill).
  - Load source is the lowest set bit of pending. If pending=0, event_valid <= 0.
  - On load: event_square <= idx, event_placed <= stable_board[idx], reported[idx] <= stable_board[idx], event_valid <= 1.
- Latency: stable_board updates on edge N; event_valid rises on edge N+1 if the register is free.
  - With event_ready held high, one event per cycle, back-to-back.
- Backpressure: while event_valid=1 and event_ready=0, event_square and event_placed hold stable.
  - Further changes on other squares accumulate in pending.
  - A further change on the held square re-enters pending and yields a later event.
- Simultaneous frame_valid and handshake in one cycle: the load uses the pre-edge stable_board and reported; the new frame's changes appear in pending the following cycle.
- baseline_done is set on the first edge after which all count[i] == STABLE_FRAMES at once.

Optional Feature:
- Macro BOARD_EVT_INIT_SUPPRESS_EN.
- Defined: until baseline_done is set, no events are loaded. On the edge baseline_done sets, reported <= stable_board (post-update value), so the initial board is captured silently and only subsequent changes produce events.
- Undefined: the reported baseline is all-zero from reset, so the first stable board emits one "placed" event per occupied square. baseline_done remains a status output only.

Decomposition:
- Shared package: NUM_SQUARES=32, SQ_IDX_W=5, an event struct/typedef {square[4:0], placed}, default STABLE_FRAMES.
- Sub-module square_debounce (candidate bit, count, stable bit, "settled" flag), instantiated 32 times via generate.
- The lowest-set-bit priority encoder and the event register stay in the top module.

Test Plan:
- STABLE_FRAMES=3, ready=1: frame 0x0000_0001 pulsed 3 times -> stable_board=0x0000_0001 after the 3rd pulse; next cycle event_valid=1, square=0, placed=1; then event_valid=0.
- Glitch: bit 5 high for 2 frames, then low for 3 -> stable_board bit 5 never set, no event.
- Frame 0x8000_0011 held 3 frames, ready=1 -> events square 0, 4, 31 on three consecutive cycles, all placed=1.
- Backpressure: ready=0 while square 0's event is held. Meanwhile square 4 goes stable 1 then stable 0, and square 31 goes stable 1. Raise ready -> only squares 0 and 31 are emitted; square 4 is never emitted.
- Reset mid-operation: event_valid=1, drive reset_n=0 for one edge -> event_valid=0, stable_board=0, baseline_done=0. The next 3 identical frames re-debounce from scratch.
- BOARD_EVT_INIT_SUPPRESS_EN defined:
  - Frame 0x00FF_0000 x3 -> baseline_done=1, no events.
  - Then frame 0x00FE_0000 x3 -> one event: square=16, placed=0.

Source files
------------

// File: rtl/board_event_detector_pkg.sv
// Shared types and constants for the board event detector: square count,
// index width, the event record and the lowest-set-bit helper.
package board_event_detector_pkg;

    localparam int NUM_SQUARES           = 32;
    localparam int SQ_IDX_W              = 5;
    localparam int DEFAULT_STABLE_FRAMES = 3;
    localparam int DEFAULT_CNT_W         = 4;

    typedef struct packed {
        logic [SQ_IDX_W-1:0] square;
        logic                placed;
    } board_event_t;

    // Scanning downward so the last hit wins gives the lowest set index.
    function automatic logic [SQ_IDX_W-1:0] lowest_set_index(input logic [NUM_SQUARES-1:0] v);
        logic [SQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SQUARES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SQ_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/board_event_detector_square_debounce.sv
// Debounces one board square: a candidate bit plus an agreement counter that
// commits the candidate to the stable bit after STABLE_FRAMES matching frames.
module board_event_detector_square_debounce #(
    parameter int STABLE_FRAMES = 3,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_valid,
    input  logic frame_bit,
    output logic stable,
    output logic stable_next,
    output logic settled_next
);

    localparam logic [CNT_W-1:0] TARGET = CNT_W'(STABLE_FRAMES);

    logic             candidate;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // The counter saturates at TARGET; the stable bit only moves when it arrives there.
    always_comb begin
        count_next  = count;
        stable_next = stable;
        if (frame_valid) begin
            if (frame_bit != candidate) begin
                count_next = CNT_W'(1);
            end else if (count != TARGET) begin
                count_next = count + 1'b1;
            end
            if (count_next == TARGET) begin
                stable_next = frame_bit;
            end
        end
    end

    assign settled_next = (count_next == TARGET);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            candidate <= 1'b0;
            count     <= '0;
            stable    <= 1'b0;
        end else begin
            if (frame_valid) begin
                candidate <= frame_bit;
            end
            count  <= count_next;
            stable <= stable_next;
        end
    end

endmodule

// File: rtl/board_event_detector.sv
// Board event detector: per-square debounce, pending-change tracking and a
// valid/ready event register. Optional macro BOARD_EVT_INIT_SUPPRESS_EN hides the initial board.
module board_event_detector
    import board_event_detector_pkg::*;
#(
    parameter int STABLE_FRAMES = DEFAULT_STABLE_FRAMES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SQUARES-1:0] frame_data,
    input  logic                   frame_valid,
    output logic [NUM_SQUARES-1:0] stable_board,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [SQ_IDX_W-1:0]    event_square,
    output logic                   event_placed,
    output logic                   baseline_done
);

`ifdef BOARD_EVT_INIT_SUPPRESS_EN
    localparam bit SUPPRESS_INIT = 1'b1;
`else
    localparam bit SUPPRESS_INIT = 1'b0;
`endif

    logic [NUM_SQUARES-1:0] stable_next;
    logic [NUM_SQUARES-1:0] settled_next;
    logic [NUM_SQUARES-1:0] reported;
    logic [NUM_SQUARES-1:0] pending;
    logic [SQ_IDX_W-1:0]    pend_idx;
    logic                   pend_any;
    logic                   baseline_set;
    logic                   load_en;
    board_event_t           event_q;

    for (genvar g = 0; g < NUM_SQUARES; g++) begin : g_square
        board_event_detector_square_debounce #(
            .STABLE_FRAMES(STABLE_FRAMES),
            .CNT_W        (CNT_W)
        ) u_square_debounce (
            .clk         (clk),
            .reset_n     (reset_n),
            .frame_valid (frame_valid),
            .frame_bit   (frame_data[g]),
            .stable      (stable_board[g]),
            .stable_next (stable_next[g]),
            .settled_next(settled_next[g])
        );
    end

    // A change that reverts before being reported drops out of pending on its own.
    assign pending      = stable_board ^ reported;
    assign pend_any     = |pending;
    assign pend_idx     = lowest_set_index(pending);
    assign baseline_set = !baseline_done && (&settled_next);
    assign load_en      = (!event_valid || event_ready) && (!SUPPRESS_INIT || baseline_done);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reported      <= '0;
            event_valid   <= 1'b0;
            event_q       <= '0;
            baseline_done <= 1'b0;
        end else begin
            if (baseline_set) begin
                baseline_done <= 1'b1;
            end
            if (SUPPRESS_INIT && baseline_set) begin
                reported <= stable_next;
            end else if (load_en && pend_any) begin
                reported[pend_idx] <= stable_board[pend_idx];
            end
            if (load_en) begin
                event_valid <= pend_any;
                if (pend_any) begin
                    event_q.square <= pend_idx;
                    event_q.placed <= stable_board[pend_idx];
                end
            end
        end
    end

    assign event_square = event_q.square;
    assign event_placed = event_q.placed;

endmodule

// File: tb/tb_board_event_detector.sv
// Scoreboard bench for board_event_detector: directed frames push expected
// events into a queue; a monitor pops and compares on every handshake.
module tb_board_event_detector;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic [31:0] stable_board;
    logic        event_valid;
    logic        event_ready;
    logic [4:0]  event_square;
    logic        event_placed;
    logic        baseline_done;

    logic [5:0]  expected_q[$];
    int          checks = 0;
    int          errors = 0;

    board_event_detector dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .stable_board (stable_board),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_square (event_square),
        .event_placed (event_placed),
        .baseline_done(baseline_done)
    );

    always #5 clk = ~clk;

    // Handshake completes on the next posedge; compare against the queue head.
    always @(negedge clk) begin
        if (reset_n && event_valid && event_ready) begin
            checks++;
            if (expected_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event: got square=%0d placed=%0d, required none",
                         event_square, event_placed);
            end else begin
                logic [5:0] exp_ev;
                exp_ev = expected_q.pop_front();
                if ({event_square, event_placed} != exp_ev) begin
                    errors++;
                    $display("[TB] FAIL event_order: got square=%0d placed=%0d, required square=%0d placed=%0d",
                             event_square, event_placed, exp_ev[5:1], exp_ev[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            frame_data  = frame;
            frame_valid = 1'b1;
            tick();
            frame_valid = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
        end
    endtask

    task automatic expectEvent(input logic [4:0] sq, input logic placed);
        expected_q.push_back({sq, placed});
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("reset_stable_board", stable_board, 32'h0);
        checkOutput("reset_event_valid", {31'h0, event_valid}, 32'h0);
        checkOutput("reset_baseline_done", {31'h0, baseline_done}, 32'h0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && expected_q.size() != 0; i++) begin
            tick();
        end
        checks++;
        if (expected_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d events outstanding, required 0", name, expected_q.size());
            expected_q.delete();
        end
        repeat (3) tick();
        checkOutput({name, "_idle"}, {31'h0, event_valid}, 32'h0);
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_data  = '0;
        frame_valid = 1'b0;
        event_ready = 1'b1;
        tick();
        tick();
        pulseReset();

`ifdef BOARD_EVT_INIT_SUPPRESS_EN
        applyStimulus(32'h00FF_0000, 2);
        checkOutput("sup_baseline_early", {31'h0, baseline_done}, 32'h0);
        applyStimulus(32'h00FF_0000, 1);
        checkOutput("sup_stable", stable_board, 32'h00FF_0000);
        checkOutput("sup_baseline_done", {31'h0, baseline_done}, 32'h1);
        drain("sup_silent");
        expectEvent(5'd16, 1'b0);
        applyStimulus(32'h00FE_0000, 3);
        checkOutput("sup_stable2", stable_board, 32'h00FE_0000);
        drain("sup_lift16");
`else
        $display("[TB] single square placement");
        expectEvent(5'd0, 1'b1);
        applyStimulus(32'h0000_0001, 2);
        checkOutput("t1_stable_early", stable_board, 32'h0);
        checkOutput("t1_baseline_early", {31'h0, baseline_done}, 32'h0);
        applyStimulus(32'h0000_0001, 1);
        checkOutput("t1_stable", stable_board, 32'h0000_0001);
        checkOutput("t1_baseline_done", {31'h0, baseline_done}, 32'h1);
        drain("t1");

        $display("[TB] glitch on square 5");
        applyStimulus(32'h0000_0021, 2);
        applyStimulus(32'h0000_0001, 3);
        checkOutput("t2_stable", stable_board, 32'h0000_0001);
        drain("t2");

        $display("[TB] three squares back to back");
        pulseReset();
        expectEvent(5'd0, 1'b1);
        expectEvent(5'd4, 1'b1);
        expectEvent(5'd31, 1'b1);
        applyStimulus(32'h8000_0011, 3);
        checkOutput("t3_stable", stable_board, 32'h8000_0011);
        drain("t3");

        $display("[TB] backpressure with cancelled square 4");
        pulseReset();
        event_ready = 1'b0;
        expectEvent(5'd0, 1'b1);
        applyStimulus(32'h0000_0001, 3);
        tick();
        tick();
        applyStimulus(32'h0000_0011, 3);
        checkOutput("t4_sq4_stable", stable_board, 32'h0000_0011);
        applyStimulus(32'h0000_0001, 3);
        applyStimulus(32'h8000_0001, 3);
        tick();
        checkOutput("t4_held_valid", {31'h0, event_valid}, 32'h1);
        checkOutput("t4_held_square", {27'h0, event_square}, 32'h0);
        checkOutput("t4_held_placed", {31'h0, event_placed}, 32'h1);
        checkOutput("t4_stable", stable_board, 32'h8000_0001);
        expectEvent(5'd31, 1'b1);
        event_ready = 1'b1;
        drain("t4");

        $display("[TB] reset while an event is held");
        event_ready = 1'b0;
        applyStimulus(32'h0000_0004, 3);
        tick();
        checkOutput("t5_held_valid", {31'h0, event_valid}, 32'h1);
        pulseReset();
        event_ready = 1'b1;
        expectEvent(5'd2, 1'b1);
        applyStimulus(32'h0000_0004, 2);
        checkOutput("t5_stable_early", stable_board, 32'h0);
        applyStimulus(32'h0000_0004, 1);
        checkOutput("t5_stable", stable_board, 32'h0000_0004);
        drain("t5");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
